// File: rtl/alu_op_scheduler_if.sv
// Request/response bundle between the requesting control logic and the ALU scheduler.
// master = requester side, slave = scheduler side.
interface alu_op_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0;
  logic [1:0]  req_op1;
  logic [7:0]  req_a0;
  logic [7:0]  req_a1;
  logic [7:0]  req_b0;
  logic [7:0]  req_b1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_result;
  logic        resp_carry;
  logic        resp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_carry, resp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_carry, resp_err
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Arbitrates two requesters onto one shared combinational ALU (add/sub/mul) and adds
// a restoring 8-bit divide built from repeated ALU subtracts; results return on one tagged channel.
module alu_op_scheduler #(
  parameter bit         RR_EN     = 1'b1,
  parameter logic [7:0] DIVZERO_Q = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_op_scheduler_if.slave         bus,
  output logic [7:0]                alu_a,
  output logic [7:0]                alu_b,
  output logic [1:0]                alu_sel,
  output logic                      alu_cin,
  input  logic [15:0]               alu_result,
  input  logic                      alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;

  state_t      state;
  logic        pref;
  logic [1:0]  op_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        id_r;
  logic [7:0]  rem;
  logic [7:0]  quot;
  logic [2:0]  cnt;

  logic        gnt_id;
  logic        accept;
  logic [1:0]  sel_op;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic        div_take;
  logic [7:0]  rem_nx;
  logic [7:0]  quot_nx;

  assign alu_cin = 1'b0;

  // Contention goes to pref under round-robin, otherwise port 0; a lone request always wins.
  always_comb begin
    gnt_id = 1'b0;
    if (bus.req_valid == 2'b11)
      gnt_id = RR_EN ? pref : 1'b0;
    else if (bus.req_valid == 2'b10)
      gnt_id = 1'b1;
  end

  assign bus.req_ready = (rst_n && state == IDLE && |bus.req_valid) ?
                         (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign accept  = |(bus.req_valid & bus.req_ready);
  assign sel_op  = gnt_id ? bus.req_op1 : bus.req_op0;
  assign sel_a   = gnt_id ? bus.req_a1  : bus.req_a0;
  assign sel_b   = gnt_id ? bus.req_b1  : bus.req_b0;

  // rem[7] set means the shifted partial remainder is 9 bits wide and certainly exceeds b.
  assign div_take = rem[7] | alu_carry;
  assign rem_nx   = div_take ? alu_result[7:0] : alu_a;
  assign quot_nx  = {quot[6:0], div_take};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pref            <= 1'b0;
      cnt             <= 3'd0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= 16'h0000;
      bus.resp_carry  <= 1'b0;
      bus.resp_err    <= 1'b0;
      alu_sel         <= 2'b11;
      alu_a           <= 8'h00;
      alu_b           <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= sel_op;
            a_r  <= sel_a;
            b_r  <= sel_b;
            id_r <= gnt_id;
            pref <= ~gnt_id;
            if (sel_op == 2'b11) begin
              state <= DIV;
              cnt   <= 3'd0;
              rem   <= 8'h00;
              quot  <= sel_a;
              if (sel_b == 8'h00) begin
                alu_sel <= 2'b11;
                alu_a   <= 8'h00;
                alu_b   <= 8'h00;
              end else begin
                alu_sel <= 2'b01;
                alu_a   <= {7'b0, sel_a[7]};
                alu_b   <= sel_b;
              end
            end else begin
              state   <= EXEC;
              alu_sel <= sel_op;
              alu_a   <= sel_a;
              alu_b   <= sel_b;
            end
          end
        end

        // ---- EXEC: single ALU cycle, result captured at its closing edge ----
        EXEC: begin
          bus.resp_valid <= 1'b1;
          bus.resp_id    <= id_r;
          bus.resp_err   <= 1'b0;
          if (op_r == 2'b10) begin
            bus.resp_result <= alu_result;
            bus.resp_carry  <= 1'b0;
          end else begin
            bus.resp_result <= {8'h00, alu_result[7:0]};
            bus.resp_carry  <= alu_carry;
          end
          alu_sel <= 2'b11;
          alu_a   <= 8'h00;
          alu_b   <= 8'h00;
          state   <= RESP;
        end

        // ---- DIV: one restoring-divide iteration per cycle ----
        DIV: begin
          if (b_r == 8'h00) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_id     <= id_r;
            bus.resp_result <= {a_r, DIVZERO_Q};
            bus.resp_carry  <= 1'b0;
            bus.resp_err    <= 1'b1;
            state           <= RESP;
          end else begin
            rem  <= rem_nx;
            quot <= quot_nx;
            cnt  <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              bus.resp_valid  <= 1'b1;
              bus.resp_id     <= id_r;
              bus.resp_result <= {rem_nx, quot_nx};
              bus.resp_carry  <= 1'b0;
              bus.resp_err    <= 1'b0;
              alu_sel         <= 2'b11;
              alu_a           <= 8'h00;
              alu_b           <= 8'h00;
              state           <= RESP;
            end else begin
              alu_a <= {rem_nx[6:0], quot_nx[7]};
            end
          end
        end

        // ---- RESP: hold the response until it is taken ----
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
